rom_stream_tx: RTL

Host-side transmitter for the tinysoc instruction-ROM load protocol. Holds an 8-entry × 15-bit program buffer. On `start` it holds the target in reset, then streams each instruction as three 5-bit quintets, one per clock, low quintet first, with no gaps. Its outputs drive the target's `io_in[1]` (reset) and `io_in[7:3]` (quintet). Both ends share `clk`.

---
 rtl/rom_stream_tx.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rom_stream_tx.sv
// rtl/rom_stream_tx.sv - host-side instruction-ROM load transmitter
//
// Holds a NUM_INSTR x 15-bit program buffer. On start it holds the target in
// reset for RST_CYCLES cycles. It then streams each instruction as three 5-bit
// quintets, low quintet first, one per clock, with no gaps.
//
// Ports:
//   clk        in   1   clock, shared with the target
//   rst        in   1   synchronous active-high reset
//   prog_we    in   1   program buffer write strobe (ignored while busy)
//   prog_addr  in   3   buffer entry to write
//   prog_data  in  15   instruction word
//   start      in   1   begin a load sequence (sampled in IDLE only)
//   tgt_rst    out  1   target reset (target io_in[1])
//   tgt_q      out  5   quintet (target io_in[7:3])
//   busy       out  1   high while in RESET or STREAM
//   done       out  1   one-cycle pulse after the last quintet was consumed
//   loaded     out  1   a full stream has completed since the last start/rst
module rom_stream_tx #(
  parameter int NUM_INSTR  = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_we,
  input  logic [2:0]  prog_addr,
  input  logic [14:0] prog_data,
  input  logic        start,
  output logic        tgt_rst,
  output logic [4:0]  tgt_q,
  output logic        busy,
  output logic        done,
  output logic        loaded
);

  localparam int IW = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
  localparam logic [IW-1:0] I_LAST   = IW'(NUM_INSTR - 1);
  localparam logic [3:0]    RST_LAST = 4'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_STREAM
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    rst_cnt_q, rst_cnt_d;
  logic [IW-1:0] i_q, i_d;
  logic [1:0]    q_q, q_d;
  logic [14:0]   pbuf_q [NUM_INSTR];
  logic [14:0]   pbuf_d [NUM_INSTR];
  logic          tgt_rst_q, tgt_rst_d;
  logic [4:0]    tgt_q_q, tgt_q_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          loaded_q, loaded_d;
  logic [IW-1:0] i_nxt;

  // Select quintet sel (0 = low) of an instruction word.
  function automatic logic [4:0] quintet(input logic [14:0] w, input logic [1:0] sel);
    case (sel)
      2'd0:    return w[4:0];
      2'd1:    return w[9:5];
      default: return w[14:10];
    endcase
  endfunction

  assign i_nxt = i_q + IW'(1);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    i_d       = i_q;
    q_d       = q_q;
    pbuf_d    = pbuf_q;
    tgt_rst_d = tgt_rst_q;
    tgt_q_d   = tgt_q_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    loaded_d  = loaded_q;

    // Writes only land in IDLE. The stream reads the buffer no earlier than
    // the RESET->STREAM edge, so a write sampled together with start is
    // already visible to the first quintet.
    if (prog_we && (state_q == S_IDLE) && (int'(prog_addr) < NUM_INSTR)) begin
      pbuf_d[prog_addr] = prog_data;
    end

    case (state_q)
      S_IDLE: begin
        tgt_q_d = 5'd0;
        if (start) begin
          state_d   = S_RESET;
          busy_d    = 1'b1;
          loaded_d  = 1'b0;
          tgt_rst_d = 1'b1;
          rst_cnt_d = 4'd0;
        end
      end

      S_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = S_STREAM;
          tgt_rst_d = 1'b0;
          tgt_q_d   = quintet(pbuf_q[0], 2'd0);
          i_d       = '0;
          q_d       = 2'd0;
        end else begin
          rst_cnt_d = rst_cnt_q + 4'd1;
        end
      end

      S_STREAM: begin
        if (q_q == 2'd2) begin
          if (i_q == I_LAST) begin
            // Last quintet has been held for its cycle: finish the load.
            state_d  = S_IDLE;
            tgt_q_d  = 5'd0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            loaded_d = 1'b1;
            i_d      = '0;
            q_d      = 2'd0;
          end else begin
            i_d     = i_nxt;
            q_d     = 2'd0;
            tgt_q_d = quintet(pbuf_q[i_nxt], 2'd0);
          end
        end else begin
          q_d     = q_q + 2'd1;
          tgt_q_d = quintet(pbuf_q[i_q], q_q + 2'd1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= 4'd0;
      i_q       <= '0;
      q_q       <= 2'd0;
      tgt_rst_q <= 1'b1;
      tgt_q_q   <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      loaded_q  <= 1'b0;
      for (int k = 0; k < NUM_INSTR; k++) begin
        pbuf_q[k] <= 15'd0;
      end
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      i_q       <= i_d;
      q_q       <= q_d;
      tgt_rst_q <= tgt_rst_d;
      tgt_q_q   <= tgt_q_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      loaded_q  <= loaded_d;
      pbuf_q    <= pbuf_d;
    end
  end

  assign tgt_rst = tgt_rst_q;
  assign tgt_q   = tgt_q_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign loaded  = loaded_q;

endmodule
